// File: rtl/muldiv_hilo_sequencer_if.sv
// Execute-stage interface to the HI/LO multiply/divide sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface muldiv_hilo_sequencer_if;
  logic        op_valid;
  logic [5:0]  funct;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (
    output op_valid, funct, operand_a, operand_b,
    input  hi_out, lo_out, busy, stall, done
  );

  modport slave (
    input  op_valid, funct, operand_a, operand_b,
    output hi_out, lo_out, busy, stall, done
  );
endinterface

// File: rtl/muldiv_hilo_sequencer.sv
// HI/LO owner: iterative shift-add multiplier and restoring divider with pipeline stall.
// Optional macro MULDIV_FAST_MULT_EN: single-cycle combinational MULT/MULTU.
module muldiv_hilo_sequencer (
  input logic                    clk,
  input logic                    reset,
  muldiv_hilo_sequencer_if.slave bus
);

  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_bzero;

  logic        w_is_md;
  logic        w_is_hilo;
  logic        w_signed;
  logic        w_accept;
  logic        w_acc_iter;
  logic [32:0] w_madd;
  logic [32:0] w_rshift;
  logic        w_ge;
  logic [31:0] w_dsub;
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  function automatic logic [31:0] f_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] f_neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] f_neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  assign w_is_md   = (bus.funct[5:2] == 4'b0110);
  assign w_is_hilo = (bus.funct[5:2] == 4'b0100);
  assign w_signed  = ~bus.funct[0];
  assign w_accept  = bus.op_valid & w_is_md & (r_state == S_IDLE);

`ifdef MULDIV_FAST_MULT_EN
  logic               w_acc_fast;
  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic        [63:0] w_fast_prod;
  assign w_acc_iter  = w_accept & bus.funct[1];
  assign w_acc_fast  = w_accept & ~bus.funct[1];
  assign w_sa        = {{32{bus.operand_a[31] & w_signed}}, bus.operand_a};
  assign w_sb        = {{32{bus.operand_b[31] & w_signed}}, bus.operand_b};
  assign w_fast_prod = w_sa * w_sb;
`else
  assign w_acc_iter = w_accept;
`endif

  // One shift-add step: add multiplicand when the low multiplier bit is set, then shift right.
  assign w_madd   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : 33'd0);
  // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
  assign w_rshift = {r_acc_hi, r_acc_lo[31]};
  assign w_ge     = (w_rshift >= {1'b0, r_b});
  assign w_dsub   = w_rshift[31:0] - r_b;

  always_comb begin
    w_prod   = f_neg64({r_acc_hi, r_acc_lo}, r_neg_q);
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (r_is_div) begin
      if (r_bzero) begin
        w_fix_hi = r_a;
        w_fix_lo = 32'hFFFF_FFFF;
      end else begin
        w_fix_hi = f_neg32(r_acc_hi, r_neg_r);
        w_fix_lo = f_neg32(r_acc_lo, r_neg_q);
      end
    end
  end

  // Working registers: loaded on accept, iterated during CALC, consumed in FIX.
  always_ff @(posedge clk) begin
    if (w_acc_iter) begin
      r_a      <= bus.operand_a;
      r_b      <= f_mag(bus.operand_b, w_signed);
      r_acc_hi <= 32'd0;
      r_acc_lo <= f_mag(bus.operand_a, w_signed);
      r_is_div <= bus.funct[1];
      r_neg_q  <= w_signed & (bus.operand_a[31] ^ bus.operand_b[31]);
      r_neg_r  <= w_signed & bus.operand_a[31];
      r_bzero  <= (bus.operand_b == 32'd0);
    end else if (r_state == S_CALC) begin
      if (r_is_div) begin
        r_acc_hi <= w_ge ? w_dsub : w_rshift[31:0];
        r_acc_lo <= {r_acc_lo[30:0], w_ge};
      end else begin
        {r_acc_hi, r_acc_lo} <= {w_madd, r_acc_lo[31:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc_iter) begin
            r_state <= S_CALC;
            r_count <= 5'd0;
            r_busy  <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
          end else if (w_acc_fast) begin
            r_hi   <= w_fast_prod[63:32];
            r_lo   <= w_fast_prod[31:0];
            r_done <= 1'b1;
`endif
          end else if (bus.op_valid && bus.funct == F_MTHI) begin
            r_hi <= bus.operand_a;
          end else if (bus.op_valid && bus.funct == F_MTLO) begin
            r_lo <= bus.operand_a;
          end
        end
        S_CALC: begin
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) begin
            r_state <= S_FIX;
            r_done  <= 1'b1;
          end
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_busy  <= 1'b0;
          r_count <= 5'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi_out = r_hi;
  assign bus.lo_out = r_lo;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.stall  = bus.op_valid & (w_is_md | w_is_hilo) & r_busy;

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Scoreboard bench for muldiv_hilo_sequencer: directed mult/div/move vectors,
// stall timing, back-to-back issue and mid-operation reset.
module tb_muldiv_hilo_sequencer;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];
  logic        mon_pend;
  logic [63:0] mon_e;

  muldiv_hilo_sequencer_if bus();

  muldiv_hilo_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid  = 1'b1;
    bus.funct     = f;
    bus.operand_a = a;
    bus.operand_b = b;
  endtask

  task automatic idle_in();
    bus.op_valid = 1'b0;
    bus.funct    = 6'd0;
  endtask

  // Present one instruction for a single cycle; returns at the negedge of the following cycle.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] e);
    if (push) exp_q.push_back(e);
    @(negedge clk);
    drive(f, a, b);
    @(negedge clk);
    idle_in();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy !== 1'b0 || exp_q.size() != 0 || mon_pend) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_idle: timed out busy=%b pending=%0d", bus.busy, exp_q.size());
    end
    @(negedge clk);
  endtask

  // Monitor: on each done pulse pop the expected HI/LO and compare once they are visible.
  initial begin
    mon_pend = 1'b0;
    mon_e    = 64'd0;
    forever begin
      @(negedge clk);
      if (mon_pend) begin
        chk("sb_hi", bus.hi_out, mon_e[63:32]);
        chk("sb_lo", bus.lo_out, mon_e[31:0]);
        mon_pend = 1'b0;
      end
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pulse");
        end else begin
          mon_e    = exp_q.pop_front();
          mon_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    int done_cnt, done_at, busy_cnt, stall_cnt, n;

    reset = 1'b1;
    bus.operand_a = 32'd0;
    bus.operand_b = 32'd0;
    idle_in();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", bus.hi_out, 32'd0);
    chk("rst_lo", bus.lo_out, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    drive(F_MFHI, 32'd0, 32'd0);
    #1;
    chk("idle_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    idle_in();

    // MULTU max x max with cycle-accurate done/busy profile
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    done_cnt = 0; done_at = 0; busy_cnt = 0;
    for (int k = 1; k <= 34; k++) begin
      if (bus.done === 1'b1) begin done_cnt++; done_at = k; end
      if (bus.busy === 1'b1) busy_cnt++;
      if (k == 34) begin
        chk("multu_hi", bus.hi_out, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo_out, 32'h0000_0001);
      end
      @(negedge clk);
    end
    chk("multu_done_cnt", done_cnt, 1);
`ifdef MULDIV_FAST_MULT_EN
    chk("multu_done_at", done_at, 1);
    chk("multu_busy_cycles", busy_cnt, 0);
`else
    chk("multu_done_at", done_at, 33);
    chk("multu_busy_cycles", busy_cnt, 33);
`endif
    wait_idle();

    issue(F_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_idle();
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_idle();
    issue(F_DIVU, 32'h0000_1234, 32'd0, 1'b1, 64'h0000_1234_FFFF_FFFF);
    wait_idle();
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
    wait_idle();
    issue(F_DIV, 32'h0000_0000, 32'd0, 1'b1, 64'h0000_0000_FFFF_FFFF);
    wait_idle();

    // DIVU 100/7 with MFLO held and operands scrambled after accept
    issue(F_DIVU, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
    stall_cnt = 0;
    for (int k = 1; k <= 34; k++) begin
      drive(F_MFLO, $urandom, $urandom);
      #1;
      if (bus.stall === 1'b1) stall_cnt++;
      if (k == 34) begin
        chk("mflo_stall_release", {31'd0, bus.stall}, 32'd0);
        chk("mflo_lo", bus.lo_out, 32'd14);
        chk("mflo_hi", bus.hi_out, 32'd2);
      end
      @(negedge clk);
    end
    idle_in();
    chk("mflo_stall_cycles", stall_cnt, 33);
    wait_idle();

    // Moves in IDLE
    issue(F_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 64'd0);
    chk("mthi_hi", bus.hi_out, 32'hDEAD_BEEF);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    issue(F_MTLO, 32'h1234_5678, 32'd0, 1'b0, 64'd0);
    chk("mtlo_lo", bus.lo_out, 32'h1234_5678);
    chk("mtlo_keeps_hi", bus.hi_out, 32'hDEAD_BEEF);

    // MTLO presented while busy waits for IDLE
    issue(F_DIVU, 32'd50, 32'd5, 1'b1, {32'd0, 32'd10});
    stall_cnt = 0;
    n = 0;
    while (n < 100) begin
      drive(F_MTLO, 32'hCAFE_F00D, 32'd0);
      #1;
      if (bus.stall !== 1'b1) break;
      stall_cnt++;
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    idle_in();
    chk("mtlo_busy_stalls", stall_cnt, 33);
    chk("mtlo_busy_lo", bus.lo_out, 32'hCAFE_F00D);
    chk("mtlo_busy_hi", bus.hi_out, 32'd0);
    wait_idle();

    // Back-to-back: second op held until the first finishes
    issue(F_MULTU, 32'd7, 32'd6, 1'b1, {32'd0, 32'd42});
    exp_q.push_back({32'd1, 32'd4});
    stall_cnt = 0;
    n = 0;
    while (n < 100) begin
      drive(F_DIVU, 32'd9, 32'd2);
      #1;
      if (bus.stall !== 1'b1) break;
      stall_cnt++;
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    idle_in();
`ifndef MULDIV_FAST_MULT_EN
    chk("b2b_stalls", stall_cnt, 33);
`endif
    wait_idle();
    chk("b2b_hi", bus.hi_out, 32'd1);
    chk("b2b_lo", bus.lo_out, 32'd4);

    // Reset in the middle of a divide discards it
    issue(F_DIV, 32'd1000, 32'd3, 1'b0, 64'd0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_hi", bus.hi_out, 32'd0);
    chk("midrst_lo", bus.lo_out, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    repeat (30) @(negedge clk);
    issue(F_MULTU, 32'd3, 32'd4, 1'b1, {32'd0, 32'd12});
    wait_idle();
    chk("post_rst_lo", bus.lo_out, 32'd12);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
